modsq_iter_ctrl: RTL

- Sequences one VDF evaluation on the modular squaring wrapper: accepts an initial value and iteration count T, resets and starts the squarer, counts its valid pulses, captures the Tth squaring result, halts the squarer and returns the result.
- Sits in the `clk` domain between the host/shell command interface and the modular squaring wrapper.
- Provides a watchdog, an abort path and a status code per command.

---
 rtl/modsq_ctrl_pkg.sv | 41 ++++
 rtl/modsq_ctrl_timer.sv | 33 +++
 rtl/modsq_iter_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modsq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modsq_ctrl_pkg
// Description : Shared types and default timing for the modular-squaring
//               iteration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package modsq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        START  = 3'd3,
        RUN    = 3'd4,
        STOP   = 3'd5,
        RESP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        TIMEOUT    = 2'd1,
        ABORT      = 2'd2,
        ZERO_ITERS = 2'd3
    } status_t;

    localparam int C_RST_CYCLES     = 16;
    localparam int C_SETTLE_CYCLES  = 32;
    localparam int C_TIMEOUT_CYCLES = 4096;

    // One extra bit so the largest load value itself is representable.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modsq_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : modsq_ctrl_timer
// Description : Loadable down-counter; expired is high while the count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module modsq_ctrl_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/modsq_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : modsq_iter_ctrl
// Description : Sequences one VDF evaluation: reset/start the squarer, count
//               T valids, capture the last result and return it with status.
// Revision    : 1.0 - initial release
// ============================================================================
module modsq_iter_ctrl
    import modsq_ctrl_pkg::*;
#(
    parameter int MOD_LEN        = 1024,
    parameter int WORD_LEN       = 16,
    parameter int NUM_ELEMENTS   = MOD_LEN / WORD_LEN + 1,
    parameter int SQ_OUT_BITS    = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int ITER_W         = 64,
    parameter int RST_CYCLES     = C_RST_CYCLES,
    parameter int SETTLE_CYCLES  = C_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [MOD_LEN-1:0]     cmd_sq_in,
    input  logic [ITER_W-1:0]      cmd_iters,
    input  logic                   cmd_abort,
    output logic                   sq_reset,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SQ_OUT_BITS-1:0] res_sq_out,
    output logic [ITER_W-1:0]      res_iters,
    output logic [1:0]             res_status,
    output logic                   busy
);

    localparam int TW = timer_width(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    // Phase timers expire on the last cycle of the phase, hence the -1.
    localparam logic [TW-1:0] RST_LOAD    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WDOG_LOAD   = TW'(TIMEOUT_CYCLES);

    state_t                   r_state;
    state_t                   w_state_n;
    status_t                  r_status;
    status_t                  w_status_n;
    logic [MOD_LEN-1:0]       r_sq_in;
    logic [ITER_W-1:0]        r_iters;
    logic [ITER_W-1:0]        r_count;
    logic [ITER_W-1:0]        w_cnt_inc;
    logic [SQ_OUT_BITS-1:0]   r_last;
    logic [SQ_OUT_BITS-1:0]   r_res_sq_out;
    logic [ITER_W-1:0]        r_res_iters;
    status_t                  r_res_status;
    logic                     w_accept;
    logic                     w_zero_cmd;
    logic                     w_capture;
    logic                     w_finish;
    logic                     w_tmr_load;
    logic [TW-1:0]            w_tmr_val;
    logic                     w_tmr_en;
    logic                     w_expired;

    modsq_ctrl_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_status_n = r_status;
        w_accept   = 1'b0;
        w_zero_cmd = 1'b0;
        w_capture  = 1'b0;
        w_finish   = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        w_cnt_inc  = r_count + ITER_W'(1);
        sq_reset   = 1'b1;
        sq_start   = 1'b0;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;

        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept   = 1'b1;
                    w_status_n = OK;
                    if (cmd_iters == '0) begin
                        w_zero_cmd = 1'b1;
                        w_status_n = ZERO_ITERS;
                        w_state_n  = RESP;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = RST_LOAD;
                        w_state_n  = RST;
                    end
                end
            end
            RST: begin
                w_tmr_en = 1'b1;
                if (cmd_abort) begin
                    w_status_n = ABORT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else if (w_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_LOAD;
                    w_state_n  = SETTLE;
                end
            end
            SETTLE: begin
                sq_reset = 1'b0;
                w_tmr_en = 1'b1;
                if (cmd_abort) begin
                    w_status_n = ABORT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else if (w_expired) begin
                    w_state_n = START;
                end
            end
            START: begin
                sq_reset   = 1'b0;
                sq_start   = 1'b1;
                w_tmr_load = 1'b1;
                if (cmd_abort) begin
                    w_status_n = ABORT;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else begin
                    w_tmr_val  = WDOG_LOAD;
                    w_state_n  = RUN;
                end
            end
            RUN: begin
                sq_reset  = 1'b0;
                w_tmr_en  = 1'b1;
                w_capture = sq_valid;
                // Final valid wins over timeout, which wins over abort.
                if (sq_valid && (w_cnt_inc == r_iters)) begin
                    w_status_n = OK;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else if (w_expired) begin
                    w_status_n = TIMEOUT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else if (cmd_abort) begin
                    w_status_n = ABORT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RST_LOAD;
                    w_state_n  = STOP;
                end else if (sq_valid) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = WDOG_LOAD;
                end
            end
            STOP: begin
                w_tmr_en = 1'b1;
                if (w_expired) begin
                    w_finish  = 1'b1;
                    w_state_n = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status     <= OK;
            r_sq_in      <= '0;
            r_iters      <= '0;
            r_count      <= '0;
            r_last       <= '0;
            r_res_sq_out <= '0;
            r_res_iters  <= '0;
            r_res_status <= OK;
        end else begin
            r_status <= w_status_n;
            if (w_accept) begin
                r_sq_in <= cmd_sq_in;
                r_iters <= cmd_iters;
                r_count <= '0;
                r_last  <= '0;
            end
            if (w_capture) begin
                r_last  <= sq_out;
                r_count <= w_cnt_inc;
            end
            if (w_zero_cmd) begin
                r_res_sq_out <= '0;
                r_res_iters  <= '0;
                r_res_status <= ZERO_ITERS;
            end else if (w_finish) begin
                r_res_sq_out <= r_last;
                r_res_iters  <= r_count;
                r_res_status <= r_status;
            end
        end
    end

    assign sq_in      = r_sq_in;
    assign res_sq_out = r_res_sq_out;
    assign res_iters  = r_res_iters;
    assign res_status = r_res_status;

endmodule
`default_nettype wire
